// File: rtl/cpu_if_pkg.sv
// Shared definitions for the instruction fetch slice: default widths,
// reset PC, the fetch packet type and the NOP encoding.
package cpu_if_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 16;
  localparam logic [AW_DEF-1:0] RESET_PC_DEF = 8'h00;

  localparam logic [DW_DEF-1:0] INSTR_NOP = 16'h0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [DW_DEF-1:0] instr;
    logic [AW_DEF-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch packet that returned from the
// ROM while the output register was stalled. Flush drops the entry,
// load captures a new packet, drain empties it once it has moved on.
module fetch_skid_buf
  import cpu_if_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       load,
  input  logic       drain,
  input  fetch_pkt_t load_pkt,
  output logic       valid,
  output fetch_pkt_t pkt
);

  // Entry register: a load in the same cycle as a drain replaces the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pkt   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pkt   <= load_pkt;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage in front of a synchronous instruction ROM. Owns the PC,
// drives the ROM address, absorbs the one-cycle ROM latency with a
// one-entry skid buffer and hands instructions to decode over
// valid/ready. A redirect pulse flushes everything and restarts fetch
// at the new address.
// Optional build macro: IF_STALL_CNT_EN adds a saturating 16-bit
// stall_cnt output counting cycles with out_valid && !out_ready.
module instr_fetch
  import cpu_if_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   DW       = DW_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          CLK,
  input  logic          RST_N,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  logic [AW-1:0] pc;
  logic          req_q;
  logic [AW-1:0] req_pc_q;

  logic          skid_valid;
  fetch_pkt_t    skid_pkt;
  fetch_pkt_t    ret_pkt;
  fetch_pkt_t    out_next;

  logic          issue;
  logic          can_accept;
  logic          out_load;
  logic          out_clear;
  logic          skid_load;
  logic          skid_drain;

  // A new ROM read is started only when the returning word is sure to
  // have somewhere to go, which keeps the skid buffer from overflowing.
  assign issue      = !skid_valid && !(out_valid && !out_ready) && !redirect_valid;
  assign can_accept = !out_valid || out_ready;
  assign ret_pkt    = '{instr: rom_data, pc: req_pc_q};
  assign rom_addr   = pc;

  // PC and in-flight tracking. The ROM samples pc at every edge; a
  // redirect puts the target on the address bus for the next edge and
  // discards whatever word is currently coming back.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc       <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_addr;
      req_q <= 1'b0;
    end else if (issue) begin
      pc       <= pc + 1'b1;
      req_q    <= 1'b1;
      req_pc_q <= pc;
    end else begin
      req_q <= 1'b0;
    end
  end

  // Steering: when the output register can take a word the skid entry
  // goes first (it is older), and a concurrent ROM return refills the
  // skid; when the output is stalled a return parks in the skid.
  always_comb begin
    out_load   = 1'b0;
    out_clear  = 1'b0;
    out_next   = ret_pkt;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (can_accept) begin
      if (skid_valid) begin
        out_load   = 1'b1;
        out_next   = skid_pkt;
        skid_drain = 1'b1;
        skid_load  = req_q;
      end else if (req_q) begin
        out_load = 1'b1;
      end else begin
        out_clear = 1'b1;
      end
    end else if (req_q) begin
      skid_load = 1'b1;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (CLK),
    .rst_n    (RST_N),
    .flush    (redirect_valid),
    .load     (skid_load),
    .drain    (skid_drain),
    .load_pkt (ret_pkt),
    .valid    (skid_valid),
    .pkt      (skid_pkt)
  );

  // Output register toward decode; holds steady while stalled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_instr <= DW'(INSTR_NOP);
      out_pc    <= '0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_instr <= out_next.instr;
      out_pc    <= out_next.pc;
    end else if (out_clear) begin
      out_valid <= 1'b0;
    end
  end

`ifdef IF_STALL_CNT_EN
  // Saturating count of cycles where decode holds off a valid instruction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
